mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage pipeline.
- Arbitrates between the two, sequences each memory transaction through a req/ack handshake, and returns read data to the winner.
- Drives per-stage stall signals. The pipeline's PC register and pipeline registers consume these the same way they consume the hazard stall.
- Sits between the datapath's fetch/memory stages and the memory model.

Parameters:
- ADDR_W, 9, byte address width (matches PC and data-memory address width)
- DATA_W, 32, data width
- FAIR_LIMIT, 4, consecutive DM grants allowed while IF waits (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  IF requests an instruction read; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  DM requests a load or store; held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_funct3  in  3  access size/sign, passed through to memory
- dm_ack  out  1  one-cycle pulse on completion
- dm_rdata  out  DATA_W  load data; 0 after a store
- stall_if  out  1  if_req & ~if_ack
- stall_dm  out  1  dm_req & ~dm_ack
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_funct3  out  3  access size
- mem_ack  in  1  memory completion pulse; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs clear to 0: if_ack, dm_ack, if_rdata, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, and the grant register.
  - stall_* remain combinational from the req inputs.
- FSM: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - If dm_req is high, DM is granted (older instruction wins). Otherwise, if if_req is high, IF is granted.
  - On a grant, the winner's addr/we/wdata/funct3 are registered onto mem_* and mem_req is set; next state is BUSY.
  - For an IF grant, mem_we=0 and mem_funct3=3'b010.
  - With no request, the block stays in IDLE and mem_req=0.
- BUSY:
  - mem_req and all mem_* outputs are held stable.
  - On mem_ack: mem_req clears, mem_rdata is captured into the granted stage's rdata register (DM store captures 0), and the granted stage's ack register is set. Next state is RESP.
  - With no mem_ack, the block waits indefinitely. There is no timeout.
- RESP:
  - The ack register is high for exactly this one cycle.
  - Requests are ignored in this state; next state is always IDLE.
  - A requester that keeps req high at the next edge issues a new transaction.
- The non-granted rdata register holds its previous value.
- Latency: request seen in IDLE at edge 0 -> mem_req at edge 1 -> mem_ack at cycle k -> stage ack at edge k+1.
  - Minimum 3 cycles request to ack with a zero-wait memory (mem_ack in the first BUSY cycle).
- Simultaneous requests: DM first. IF is granted in the IDLE following DM's RESP if if_req is still high.
- Requests changing during BUSY/RESP do not affect the in-flight transaction. A requester dropping req mid-transaction is a protocol violation; the transaction still completes and ack still pulses.
- mem_ack in IDLE or RESP is ignored.
- Reset mid-transaction: mem_req drops asynchronously and no ack is produced. The memory model must abort.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- When defined:
  - A saturating counter counts consecutive DM grants made while if_req was high.
  - When it reaches FAIR_LIMIT and both requests are pending in IDLE, IF is granted instead.
  - The counter clears on any IF grant or when if_req is low in IDLE; it resets to 0.
- When undefined: strict DM priority; counter logic is absent.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_e {IDLE, BUSY, RESP}
  - grant_e {GNT_IF, GNT_DM}
  - struct mem_req_t {we, addr, wdata, funct3}
  - constant FUNCT3_WORD = 3'b010
- Sub-module mem_arb_fair_ctr holds the fairness counter with a FAIR_LIMIT parameter and a sat output. It is instantiated only under MEM_ARB_FAIR_EN.

Test Plan:
- if_req=1, if_addr=0x004, memory with 0 wait states returning 0x00500093 -> mem_req rises edge 1 with mem_addr=0x004, mem_we=0; if_ack pulses one cycle with if_rdata=0x00500093; stall_if high until that cycle.
- dm_req=1, dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF, funct3=3'b010, memory with 3 wait states -> mem_* held stable 4 cycles; dm_ack one pulse; dm_rdata=0.
- if_req and dm_req both raised the same cycle (DM load from 0x020 returning 0x12345678) -> DM served first with dm_rdata=0x12345678; IF mem_req starts 2 edges after dm_ack's edge; stall_if high throughout.
- reset=0 asserted during BUSY of a DM load -> mem_req, dm_ack and dm_rdata 0 immediately; after release, a held if_req is granted first.
- MEM_ARB_FAIR_EN, FAIR_LIMIT=4, dm_req and if_req held continuously -> grant sequence DM,DM,DM,DM,IF,DM…; without the macro, IF is never granted.
- Back-to-back IF requests with if_req held high across ack -> a new mem_req is issued every 3 cycles with a zero-wait memory; no duplicate ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/DM memory port arbiter
package mem_arb_pkg;

    // Widths of the shared memory command; the arbiter's ADDR_W/DATA_W default to these
    localparam int ARB_ADDR_W = 9;
    localparam int ARB_DATA_W = 32;

    // Instruction fetches are always full-word reads
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// rtl/mem_arb_fair_ctr.sv - saturating count of DM grants made while IF waits (used under MEM_ARB_FAIR_EN)
module mem_arb_fair_ctr #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count up to FAIR_LIMIT and hold there; clear takes priority over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt >= CW'(FAIR_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for a single-ported unified memory; MEM_ARB_FAIR_EN enables IF starvation relief
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // mem_req_t is sized by the package widths, so ADDR_W/DATA_W are expected to match them
    arb_state_e state;
    grant_e     grant;
    mem_req_t   cmd;
    mem_req_t   next_cmd;
    logic       fair_sat;
    logic       if_wins;
    logic       dm_wins;

`ifdef MEM_ARB_FAIR_EN
    logic fair_inc;
    logic fair_clr;

    assign fair_inc = (state == IDLE) & dm_wins & if_req;
    assign fair_clr = (state == IDLE) & (if_wins | ~if_req);

    mem_arb_fair_ctr #(
        .FAIR_LIMIT(FAIR_LIMIT)
    ) u_fair_ctr (
        .clk  (clk),
        .reset(reset),
        .inc  (fair_inc),
        .clr  (fair_clr),
        .sat  (fair_sat)
    );
`else
    assign fair_sat = 1'b0;
`endif

    // DM (the older instruction) wins unless IF has been starved for FAIR_LIMIT DM grants
    assign if_wins = if_req & (~dm_req | (fair_sat & (FAIR_LIMIT > 0)));
    assign dm_wins = dm_req & ~if_wins;

    // Stalls follow the request lines directly so they also hold during reset
    assign stall_if = if_req & ~if_ack;
    assign stall_dm = dm_req & ~dm_ack;

    assign mem_we     = cmd.we;
    assign mem_addr   = cmd.addr;
    assign mem_wdata  = cmd.wdata;
    assign mem_funct3 = cmd.funct3;

    // Build the command for whichever stage would win this cycle
    always_comb begin
        next_cmd.we     = 1'b0;
        next_cmd.addr   = if_addr;
        next_cmd.wdata  = '0;
        next_cmd.funct3 = FUNCT3_WORD;
        if (dm_wins) begin
            next_cmd.we     = dm_we;
            next_cmd.addr   = dm_addr;
            next_cmd.wdata  = dm_wdata;
            next_cmd.funct3 = dm_funct3;
        end
    end

    // Transaction sequencer: grant in IDLE, wait for mem_ack in BUSY, pulse the stage ack in RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= GNT_IF;
            cmd      <= '0;
            mem_req  <= 1'b0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_wins || if_wins) begin
                        grant   <= dm_wins ? GNT_DM : GNT_IF;
                        cmd     <= next_cmd;
                        mem_req <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (grant == GNT_DM) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= cmd.we ? '0 : mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a wait-state memory model
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [8:0]  if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [8:0]  dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [2:0]  dm_funct3 = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_dm;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(9),
        .DATA_W(32),
        .FAIR_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_grant[$];
    txn_t exp_resp[$];

    task automatic push_grant(input logic is_dm, input logic we, input logic [8:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] rdata);
        txn_t t;
        t.is_dm = is_dm; t.we = we; t.addr = addr; t.wdata = wdata; t.f3 = f3; t.rdata = rdata;
        exp_grant.push_back(t);
    endtask

    task automatic push_txn(input logic is_dm, input logic we, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] rdata);
        txn_t t;
        t.is_dm = is_dm; t.we = we; t.addr = addr; t.wdata = wdata; t.f3 = f3; t.rdata = rdata;
        exp_grant.push_back(t);
        exp_resp.push_back(t);
    endtask

    // Memory model: acks after mem_wait extra cycles, aborts when mem_req drops
    logic [31:0] mem [0:127];
    int          mem_wait = 0;
    int          wcnt = 0;
    bit          preloaded = 1'b0;

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 128; i++) mem[i] = 32'h0;
            mem[0]    = 32'h0000_0013;
            mem[1]    = 32'h0050_0093;
            mem[2]    = 32'h00A0_0113;
            mem[3]    = 32'h00F0_0193;
            mem[8]    = 32'h1234_5678;
            mem[12]   = 32'hCAFE_F00D;
            preloaded = 1'b1;
        end
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (wcnt == mem_wait) begin
            mem_ack = 1'b1;
            wcnt    = 0;
            if (mem_we) begin
                mem[mem_addr[8:2]] = mem_wdata;
                mem_rdata = 32'hFFFF_FFFF;
            end else begin
                mem_rdata = mem[mem_addr[8:2]];
            end
        end else begin
            wcnt++;
        end
    end

    // Monitor: checks grants, held commands, acks and stalls against the scoreboard
    logic prev_req = 1'b0;
    txn_t cur;
    int   cyc = 0;
    int   ack_count = 0;
    int   rise_cyc[$];

    always @(negedge clk) begin
        txn_t t;
        #2;
        cyc++;
        if (reset) begin
            check("stall_if", stall_if, if_req & ~if_ack);
            check("stall_dm", stall_dm, dm_req & ~dm_ack);
            if (mem_req && !prev_req) begin
                rise_cyc.push_back(cyc);
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    cur = exp_grant.pop_front();
                    check("grant_we", mem_we, cur.we);
                    check("grant_addr", mem_addr, cur.addr);
                    check("grant_funct3", mem_funct3, cur.f3);
                    if (cur.we) check("grant_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_req && prev_req) begin
                check("held_addr", mem_addr, cur.addr);
                check("held_we", mem_we, cur.we);
            end
            if (if_ack && dm_ack) check("dual_ack", 1'b1, 1'b0);
            if (if_ack || dm_ack) begin
                ack_count++;
                if (exp_resp.size() == 0) begin
                    check("unexpected_ack", 1'b1, 1'b0);
                end else begin
                    t = exp_resp.pop_front();
                    check("ack_stage_is_dm", dm_ack, t.is_dm);
                    check("ack_rdata", t.is_dm ? dm_rdata : if_rdata, t.rdata);
                end
            end
        end
        prev_req = mem_req;
    end

    task automatic wait_ack(input bit dm, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dm ? dm_ack : if_ack) && n < limit);
        check(dm ? "dm_ack_seen" : "if_ack_seen", dm ? dm_ack : if_ack, 1'b1);
    endtask

    task automatic wait_acks(input int target, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (ack_count < target && n < limit);
        check("ack_count_reached", ack_count, target);
    endtask

    initial begin
        int n;
        int held;
        int base;
        int rb;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_dm_ack", dm_ack, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 9'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_funct3", mem_funct3, 3'h0);
        if_req = 1'b1;
        #1;
        check("rst_stall_if_comb", stall_if, 1'b1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single IF fetch, zero-wait memory
        mem_wait = 0;
        push_txn(1'b0, 1'b0, 9'h004, 32'h0, 3'b010, 32'h0050_0093);
        if_req = 1'b1; if_addr = 9'h004;
        @(negedge clk);
        check("t1_mem_req_edge1", mem_req, 1'b1);
        check("t1_stall_if", stall_if, 1'b1);
        wait_ack(1'b0, 10, n);
        check("t1_ack_latency", n, 1);
        check("t1_stall_if_at_ack", stall_if, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        check("t1_ack_one_cycle", if_ack, 1'b0);

        // DM store with three wait states
        mem_wait = 3;
        push_txn(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 32'h0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h010; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b010;
        held = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_req) held++;
        end while (!dm_ack && n < 20);
        check("t2_dm_ack", dm_ack, 1'b1);
        check("t2_req_held_cycles", held, 4);
        check("t2_store_landed", mem[4], 32'hDEAD_BEEF);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        check("t2_ack_one_cycle", dm_ack, 1'b0);

        // Simultaneous requests: DM load first, IF two edges after dm_ack
        mem_wait = 0;
        push_txn(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h1234_5678);
        push_txn(1'b0, 1'b0, 9'h008, 32'h0, 3'b010, 32'h00A0_0113);
        dm_req = 1'b1; dm_addr = 9'h020; if_req = 1'b1; if_addr = 9'h008;
        wait_ack(1'b1, 10, n);
        check("t3_stall_if_during_dm", stall_if, 1'b1);
        dm_req = 1'b0;
        @(negedge clk);
        check("t3_no_req_in_resp_idle", mem_req, 1'b0);
        @(negedge clk);
        check("t3_if_req_2_edges_after", mem_req, 1'b1);
        wait_ack(1'b0, 10, n);
        if_req = 1'b0;
        @(negedge clk);

        // Reset during BUSY of a DM load, with IF held
        mem_wait = 6;
        push_grant(1'b1, 1'b0, 9'h030, 32'h0, 3'b010, 32'h0);
        dm_req = 1'b1; dm_addr = 9'h030; if_req = 1'b1; if_addr = 9'h00C;
        repeat (2) @(negedge clk);
        check("t4_busy_before_reset", mem_req, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("t4_rst_mem_req", mem_req, 1'b0);
        check("t4_rst_dm_ack", dm_ack, 1'b0);
        check("t4_rst_dm_rdata", dm_rdata, 32'h0);
        dm_req = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        push_txn(1'b0, 1'b0, 9'h00C, 32'h0, 3'b010, 32'h00F0_0193);
        #3;
        reset = 1'b1;
        wait_ack(1'b0, 10, n);
        check("t4_if_after_reset_latency", n, 2);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Both requests held continuously
        base = ack_count;
`ifdef MEM_ARB_FAIR_EN
        for (int i = 0; i < 4; i++) push_txn(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h1234_5678);
        push_txn(1'b0, 1'b0, 9'h000, 32'h0, 3'b010, 32'h0000_0013);
        push_txn(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h1234_5678);
`else
        for (int i = 0; i < 6; i++) push_txn(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h1234_5678);
`endif
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h020; if_req = 1'b1; if_addr = 9'h000;
        wait_acks(base + 6, 100);
        dm_req = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back IF fetches with if_req held across ack
        base = ack_count;
        rb = rise_cyc.size();
        for (int i = 0; i < 3; i++) push_txn(1'b0, 1'b0, 9'h004, 32'h0, 3'b010, 32'h0050_0093);
        if_req = 1'b1; if_addr = 9'h004;
        wait_acks(base + 3, 60);
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_rises", rise_cyc.size() - rb, 3);
        if (rise_cyc.size() >= rb + 3) begin
            check("t6_interval_1", rise_cyc[rb + 1] - rise_cyc[rb], 3);
            check("t6_interval_2", rise_cyc[rb + 2] - rise_cyc[rb + 1], 3);
        end
        check("sb_grants_drained", exp_grant.size(), 0);
        check("sb_resps_drained", exp_resp.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
